// File: rtl/seq_detector_param.sv
// Serial N-bit pattern detector with don't-care mask, build-time overlap mode and a saturating match counter.
// One-cycle latency from the completing bit to the y_out[0] pulse; all outputs are registered.
module seq_detector_param #(
  parameter int            N       = 4,
  parameter logic [N-1:0]  PATTERN = 4'b1011,
  parameter logic [N-1:0]  MASK    = {N{1'b1}},
  parameter bit            OVERLAP = 1'b1,
  parameter int            CNT_W   = 8,
  localparam int           FW      = $clog2(N+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             x_valid,
  input  logic             x_in,
  output logic [1:0]       y_out,
  output logic [CNT_W-1:0] match_count,
  output logic [FW-1:0]    fill
);

  logic [N-1:0]     window_q, window_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [1:0]       y_q, y_d;
  logic [N-1:0]     nxt;
  logic             armed;
  logic             hit;

  assign nxt   = {window_q[N-2:0], x_in};
  // ARMED once N-1 bits are held: the next valid bit can complete a match.
  assign armed = (fill_q >= FW'(N-1));

  always_comb begin
    window_d = window_q;
    fill_d   = fill_q;
    count_d  = count_q;
    y_d      = y_q;
    hit      = 1'b0;
    if (clear) begin
      window_d = '0;
      fill_d   = '0;
      count_d  = '0;
      y_d      = 2'b00;
    end else if (x_valid) begin
      hit      = armed && (((nxt ^ PATTERN) & MASK) == '0);
      window_d = nxt;
      fill_d   = (fill_q == FW'(N)) ? fill_q : fill_q + FW'(1);
      y_d[0]   = hit;
      if (hit) begin
        y_d[1]  = 1'b1;
        count_d = (&count_q) ? count_q : count_q + CNT_W'(1);
        if (!OVERLAP) begin
          window_d = '0;
          fill_d   = '0;
        end
      end
    end else begin
      y_d[0] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      window_q <= '0;
      fill_q   <= '0;
      count_q  <= '0;
      y_q      <= 2'b00;
    end else begin
      window_q <= window_d;
      fill_q   <= fill_d;
      count_q  <= count_d;
      y_q      <= y_d;
    end
  end

  assign y_out       = y_q;
  assign match_count = count_q;
  assign fill        = fill_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param; four build variants share one stimulus stream.
module tb_seq_detector_param;

  logic clk = 1'b0;
  logic reset, clear, x_valid, x_in;
  int   vectors = 0;
  int   errors  = 0;

  logic [1:0] y_ov, y_no, y_n2, y_mk;
  logic [7:0] c_ov, c_no, c_mk;
  logic [1:0] c_n2;
  logic [2:0] f_ov, f_no, f_mk;
  logic [1:0] f_n2;

  always #5 clk = ~clk;

  seq_detector_param #(.N(4), .PATTERN(4'b1011), .MASK(4'b1111), .OVERLAP(1'b1), .CNT_W(8)) u_ov (
    .clk(clk), .reset(reset), .clear(clear), .x_valid(x_valid), .x_in(x_in),
    .y_out(y_ov), .match_count(c_ov), .fill(f_ov));

  seq_detector_param #(.N(4), .PATTERN(4'b1011), .MASK(4'b1111), .OVERLAP(1'b0), .CNT_W(8)) u_no (
    .clk(clk), .reset(reset), .clear(clear), .x_valid(x_valid), .x_in(x_in),
    .y_out(y_no), .match_count(c_no), .fill(f_no));

  seq_detector_param #(.N(2), .PATTERN(2'b11), .MASK(2'b11), .OVERLAP(1'b1), .CNT_W(2)) u_n2 (
    .clk(clk), .reset(reset), .clear(clear), .x_valid(x_valid), .x_in(x_in),
    .y_out(y_n2), .match_count(c_n2), .fill(f_n2));

  seq_detector_param #(.N(4), .PATTERN(4'b1001), .MASK(4'b1001), .OVERLAP(1'b1), .CNT_W(8)) u_mk (
    .clk(clk), .reset(reset), .clear(clear), .x_valid(x_valid), .x_in(x_in),
    .y_out(y_mk), .match_count(c_mk), .fill(f_mk));

  // Called at a falling edge; returns at the falling edge after the sampling edge.
  task automatic send_bit(input logic b);
    x_valid = 1'b1;
    x_in    = b;
    @(negedge clk);
    x_valid = 1'b0;
    x_in    = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if (y_ov !== 2'b00 || c_ov !== 8'd0 || f_ov !== 3'd0) begin
      errors++;
      $display("FAIL reset_state: y=%b cnt=%0d fill=%0d, expected y=00 cnt=0 fill=0", y_ov, c_ov, f_ov);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_overlap();
    logic [6:0] s = 7'b1011011;
    logic [6:0] p = '0;
    do_clear();
    for (int i = 6; i >= 0; i--) begin
      send_bit(s[i]);
      p = {p[5:0], y_ov[0]};
    end
    vectors++;
    if (p !== 7'b0001001) begin
      errors++;
      $display("FAIL overlap_pulses: got %b expected 0001001", p);
    end
    @(negedge clk);
    vectors++;
    if (y_ov !== 2'b10 || c_ov !== 8'd2 || f_ov !== 3'd4) begin
      errors++;
      $display("FAIL overlap_end: y=%b cnt=%0d fill=%0d, expected y=10 cnt=2 fill=4", y_ov, c_ov, f_ov);
    end
  endtask

  task automatic test_non_overlap();
    logic [6:0] s  = 7'b1011011;
    logic [7:0] s2 = 8'b10111011;
    logic [6:0] p  = '0;
    logic [7:0] p2 = '0;
    do_clear();
    for (int i = 6; i >= 0; i--) begin
      send_bit(s[i]);
      p = {p[5:0], y_no[0]};
    end
    vectors++;
    if (p !== 7'b0001000) begin
      errors++;
      $display("FAIL nonoverlap_pulses: got %b expected 0001000", p);
    end
    vectors++;
    if (c_no !== 8'd1 || f_no !== 3'd3) begin
      errors++;
      $display("FAIL nonoverlap_end: cnt=%0d fill=%0d, expected cnt=1 fill=3", c_no, f_no);
    end
    do_clear();
    for (int i = 7; i >= 0; i--) begin
      send_bit(s2[i]);
      p2 = {p2[6:0], y_no[0]};
    end
    vectors++;
    if (p2 !== 8'b00010001 || c_no !== 8'd2) begin
      errors++;
      $display("FAIL nonoverlap_restart: pulses=%b cnt=%0d, expected pulses=00010001 cnt=2", p2, c_no);
    end
  endtask

  task automatic test_gap();
    do_clear();
    send_bit(1'b1);
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (f_ov !== 3'd2 || y_ov[0] !== 1'b0) begin
        errors++;
        $display("FAIL gap_hold: fill=%0d pulse=%b, expected fill=2 pulse=0", f_ov, y_ov[0]);
      end
    end
    send_bit(1'b1);
    send_bit(1'b1);
    vectors++;
    if (y_ov !== 2'b11 || c_ov !== 8'd1) begin
      errors++;
      $display("FAIL gap_match: y=%b cnt=%0d, expected y=11 cnt=1", y_ov, c_ov);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] p = '0;
    do_clear();
    for (int i = 0; i < 6; i++) begin
      send_bit(1'b1);
      p = {p[4:0], y_n2[0]};
    end
    vectors++;
    if (p !== 6'b011111) begin
      errors++;
      $display("FAIL b2b_pulses: got %b expected 011111", p);
    end
    vectors++;
    if (c_n2 !== 2'd3 || y_n2[1] !== 1'b1) begin
      errors++;
      $display("FAIL b2b_saturate: cnt=%0d sticky=%b, expected cnt=3 sticky=1", c_n2, y_n2[1]);
    end
  endtask

  task automatic test_reset_clear();
    logic [5:0] s = 6'b101101;
    do_clear();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    #2;
    reset = 1'b0;
    #1;
    vectors++;
    if (f_ov !== 3'd0 || y_ov !== 2'b00 || c_ov !== 8'd0) begin
      errors++;
      $display("FAIL async_reset: fill=%0d y=%b cnt=%0d, expected all 0", f_ov, y_ov, c_ov);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    send_bit(1'b1);
    vectors++;
    if (y_ov !== 2'b00 || f_ov !== 3'd1 || c_ov !== 8'd0) begin
      errors++;
      $display("FAIL reset_progress: y=%b fill=%0d cnt=%0d, expected y=00 fill=1 cnt=0", y_ov, f_ov, c_ov);
    end
    do_clear();
    for (int i = 5; i >= 0; i--) send_bit(s[i]);
    vectors++;
    if (y_ov !== 2'b10 || c_ov !== 8'd1) begin
      errors++;
      $display("FAIL pre_clear: y=%b cnt=%0d, expected y=10 cnt=1", y_ov, c_ov);
    end
    clear   = 1'b1;
    x_valid = 1'b1;
    x_in    = 1'b1;
    @(negedge clk);
    clear   = 1'b0;
    x_valid = 1'b0;
    x_in    = 1'b0;
    vectors++;
    if (y_ov !== 2'b00 || c_ov !== 8'd0 || f_ov !== 3'd0) begin
      errors++;
      $display("FAIL clear_priority: y=%b cnt=%0d fill=%0d, expected all 0", y_ov, c_ov, f_ov);
    end
  endtask

  task automatic test_mask();
    logic [3:0] s [3] = '{4'b1111, 4'b1001, 4'b0111};
    logic       exp [3] = '{1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 3; k++) begin
      do_clear();
      for (int i = 3; i >= 0; i--) send_bit(s[k][i]);
      vectors++;
      if (y_mk[0] !== exp[k] || c_mk !== {7'd0, exp[k]}) begin
        errors++;
        $display("FAIL mask_%b: pulse=%b cnt=%0d, expected pulse=%b cnt=%0d", s[k], y_mk[0], c_mk, exp[k], exp[k]);
      end
    end
  endtask

  initial begin
    reset   = 1'b0;
    clear   = 1'b0;
    x_valid = 1'b0;
    x_in    = 1'b0;
    test_reset();
    test_overlap();
    test_non_overlap();
    test_gap();
    test_back_to_back();
    test_reset_clear();
    test_mask();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
